// File: rtl/uart_baud_gen.sv
// -----------------------------------------------------------------------------
// uart_baud_gen
//   UART baud generator. A programmable prescaler divides clk down to an
//   oversampling tick (rx_tick). An oversample counter turns OVERSAMPLE of those
//   into one per-bit tick (tx_tick) and a ~50% square wave (baud).
//   A shadow copy of the configuration detects software rewrites and restarts
//   the generator cleanly.
//
//   Optional feature macro: UART_BAUD_FRAC_EN
//     Defined   : the fractional divisor `frac` is accumulated, and the period
//                 is stretched by one cycle on each accumulator carry.
//     Undefined : `frac` is ignored and every period is `divisor` cycles.
//
// Parameters
//   DIV_W      : width of the integer divisor
//   FRAC_W     : width of the fractional divisor (1/2^FRAC_W cycle units)
//   OVERSAMPLE : oversample ticks per bit (power of two, >= 2)
//
// Ports
//   clk         : system clock, all logic on the rising edge
//   rst         : synchronous active-high reset
//   enable      : run generator; low holds counters at 0 and emits no ticks
//   divisor     : clk cycles per rx_tick (0 is invalid)
//   frac        : fractional extension of divisor
//   rx_resync   : 1-cycle pulse from RX start-bit detect, realigns bit phase
//   rx_tick     : 1-cycle pulse, OVERSAMPLE times per bit
//   tx_tick     : 1-cycle pulse, once per bit
//   baud        : high for the first OVERSAMPLE/2 ticks of each bit
//   cfg_changed : 1-cycle pulse after divisor/frac differ from the running config
//   cfg_err     : level, divisor == 0
// -----------------------------------------------------------------------------
module uart_baud_gen #(
    parameter int DIV_W      = 16,
    parameter int FRAC_W     = 4,
    parameter int OVERSAMPLE = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [DIV_W-1:0]  divisor,
    input  logic [FRAC_W-1:0] frac,
    input  logic              rx_resync,
    output logic              rx_tick,
    output logic              tx_tick,
    output logic              baud,
    output logic              cfg_changed,
    output logic              cfg_err
);

    localparam int OS_W = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [OS_W-1:0]  OS_ZERO  = {OS_W{1'b0}};
    localparam logic [OS_W-1:0]  OS_ONE   = OS_W'(1);
    localparam logic [OS_W-1:0]  OS_LAST  = OS_W'(OVERSAMPLE - 1);
    localparam logic [OS_W-1:0]  OS_HALF  = OS_W'(OVERSAMPLE / 2);
    localparam logic [DIV_W-1:0] DIV_ZERO = {DIV_W{1'b0}};
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
    localparam logic [DIV_W:0]   EXT_ONE  = (DIV_W + 1)'(1);
    localparam logic [DIV_W:0]   EXT_ZERO = {(DIV_W + 1){1'b0}};

    logic [DIV_W-1:0] pre_cnt_r;
    logic [DIV_W-1:0] pre_cnt_nxt_s;
    logic [OS_W-1:0]  os_cnt_r;
    logic [OS_W-1:0]  os_cnt_nxt_s;
    logic [DIV_W-1:0] shadow_div_r;
    logic [DIV_W:0]   period_m1_s;
    logic             cfg_diff_s;
    logic             run_s;
    logic             restart_s;
    logic             carry_s;
    logic             wrap_s;
    logic             tick_s;
    logic             tx_nxt_s;
    logic             baud_nxt_s;

`ifdef UART_BAUD_FRAC_EN
    logic [FRAC_W-1:0] shadow_frac_r;
    logic [FRAC_W-1:0] frac_acc_r;
    logic [FRAC_W-1:0] frac_acc_nxt_s;
    logic [FRAC_W:0]   frac_sum_s;

    // The addition that will be committed at the end of the current period
    // decides whether this period is stretched, so the average period stays
    // exactly divisor + frac/2^FRAC_W from the first period after a restart.
    assign frac_sum_s = {1'b0, frac_acc_r} + {1'b0, frac};
    assign carry_s    = frac_sum_s[FRAC_W];
    assign cfg_diff_s = (divisor != shadow_div_r) || (frac != shadow_frac_r);
`else
    logic unused_frac_s;

    assign unused_frac_s = ^frac;
    assign carry_s       = 1'b0;
    assign cfg_diff_s    = (divisor != shadow_div_r);
`endif

    assign run_s       = enable && (divisor != DIV_ZERO);
    assign restart_s   = cfg_diff_s || !run_s;
    assign period_m1_s = {1'b0, divisor} + (carry_s ? EXT_ONE : EXT_ZERO) - EXT_ONE;
    assign wrap_s      = ({1'b0, pre_cnt_r} == period_m1_s);

    // Next-state logic for prescaler and oversample counter, plus tick decode.
    always_comb begin
        pre_cnt_nxt_s = pre_cnt_r;
        os_cnt_nxt_s  = os_cnt_r;
        tick_s        = 1'b0;
        tx_nxt_s      = 1'b0;
        if (restart_s) begin
            // Config change, disabled or divisor==0: hold everything at zero.
            pre_cnt_nxt_s = DIV_ZERO;
            os_cnt_nxt_s  = OS_ZERO;
        end else if (rx_resync) begin
            // Realign bit phase; a tick due this cycle is swallowed.
            pre_cnt_nxt_s = DIV_ZERO;
            os_cnt_nxt_s  = OS_ZERO;
        end else if (wrap_s) begin
            pre_cnt_nxt_s = DIV_ZERO;
            os_cnt_nxt_s  = os_cnt_r + OS_ONE;
            tick_s        = 1'b1;
            tx_nxt_s      = (os_cnt_r == OS_LAST);
        end else begin
            pre_cnt_nxt_s = pre_cnt_r + DIV_ONE;
        end
        baud_nxt_s = run_s && (os_cnt_nxt_s < OS_HALF);
    end

    // Counter, shadow config and registered output update.
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_cnt_r    <= DIV_ZERO;
            os_cnt_r     <= OS_ZERO;
            shadow_div_r <= DIV_ONE;
            rx_tick      <= 1'b0;
            tx_tick      <= 1'b0;
            baud         <= 1'b0;
            cfg_changed  <= 1'b0;
            cfg_err      <= 1'b0;
        end else begin
            pre_cnt_r    <= pre_cnt_nxt_s;
            os_cnt_r     <= os_cnt_nxt_s;
            shadow_div_r <= divisor;
            rx_tick      <= tick_s;
            tx_tick      <= tx_nxt_s;
            baud         <= baud_nxt_s;
            cfg_changed  <= cfg_diff_s;
            cfg_err      <= (divisor == DIV_ZERO);
        end
    end

`ifdef UART_BAUD_FRAC_EN
    // Fractional accumulator: cleared on restart, advanced on each prescaler
    // wrap, untouched by rx_resync.
    always_comb begin
        frac_acc_nxt_s = frac_acc_r;
        if (restart_s) begin
            frac_acc_nxt_s = {FRAC_W{1'b0}};
        end else if (tick_s) begin
            frac_acc_nxt_s = frac_sum_s[FRAC_W-1:0];
        end else begin
            frac_acc_nxt_s = frac_acc_r;
        end
    end

    // Fractional accumulator and shadow frac registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            frac_acc_r    <= {FRAC_W{1'b0}};
            shadow_frac_r <= {FRAC_W{1'b0}};
        end else begin
            frac_acc_r    <= frac_acc_nxt_s;
            shadow_frac_r <= frac;
        end
    end
`endif

endmodule
